// File: rtl/button_reader.sv
// Debounced push-button reader: 2-FF synchroniser, then one debounce/hold FSM per
// button producing a level, press/release/long-press pulses and a wrapping press count.
module button_reader #(
    parameter int CLOCK_XTAL     = 27000000,
    parameter int BTN_NUM        = 2,
    parameter int DEBOUNCE_MS    = 10,
    parameter int LONG_PRESS_MS  = 1000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_NUM-1:0]   btns_in,
    output logic [BTN_NUM-1:0]   btn_level,
    output logic [BTN_NUM-1:0]   btn_press,
    output logic [BTN_NUM-1:0]   btn_release,
    output logic [BTN_NUM-1:0]   btn_long,
    output logic [8*BTN_NUM-1:0] press_cnt
);
    localparam int CYC_PER_MS = CLOCK_XTAL / 1000;
    localparam int DB_CYC     = CYC_PER_MS * DEBOUNCE_MS;
    localparam int LP_CYC     = CYC_PER_MS * LONG_PRESS_MS;
    localparam int DB_W       = $clog2(DB_CYC) + 1;
    localparam int LP_W       = $clog2(LP_CYC) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYC - 1);
    localparam logic [BTN_NUM-1:0] IDLE_PIN = BTN_ACTIVE_LOW ? {BTN_NUM{1'b1}} : {BTN_NUM{1'b0}};

    typedef enum logic [2:0] {IDLE, CHK_PRESS, PRESSED, HELD, CHK_REL} state_t;

    logic [BTN_NUM-1:0] sync1_reg;
    logic [BTN_NUM-1:0] sync2_reg;
    logic [BTN_NUM-1:0] p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= IDLE_PIN;
            sync2_reg <= IDLE_PIN;
        end else begin
            sync1_reg <= btns_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign p = BTN_ACTIVE_LOW ? ~sync2_reg : sync2_reg;

    always_ff @(posedge clk) begin
        assert (LONG_PRESS_MS > DEBOUNCE_MS && DB_CYC >= 2);
    end

    for (genvar gi = 0; gi < BTN_NUM; gi++) begin : g_btn
        state_t            state_reg, state_next;
        logic [DB_W-1:0]   db_reg, db_next;
        logic [LP_W-1:0]   hold_reg, hold_next;
        logic              long_done_reg, long_done_next;
        logic              level_reg, level_next;
        logic              press_reg, press_next;
        logic              release_reg, release_next;
        logic              long_reg, long_next;
        logic [7:0]        cnt_reg, cnt_next;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg     <= IDLE;
                db_reg        <= '0;
                hold_reg      <= '0;
                long_done_reg <= 1'b0;
                level_reg     <= 1'b0;
                press_reg     <= 1'b0;
                release_reg   <= 1'b0;
                long_reg      <= 1'b0;
                cnt_reg       <= 8'd0;
            end else begin
                state_reg     <= state_next;
                db_reg        <= db_next;
                hold_reg      <= hold_next;
                long_done_reg <= long_done_next;
                level_reg     <= level_next;
                press_reg     <= press_next;
                release_reg   <= release_next;
                long_reg      <= long_next;
                cnt_reg       <= cnt_next;
            end
        end

        always_comb begin
            state_next     = state_reg;
            db_next        = db_reg;
            hold_next      = hold_reg;
            long_done_next = long_done_reg;
            level_next     = level_reg;
            press_next     = 1'b0;
            release_next   = 1'b0;
            long_next      = 1'b0;
            cnt_next       = cnt_reg;
            case (state_reg)
                IDLE: begin
                    if (p[gi]) begin
                        state_next = CHK_PRESS;
                        db_next    = '0;
                    end
                end
                CHK_PRESS: begin
                    if (!p[gi]) begin
                        state_next = IDLE;
                    end else if (db_reg == DB_LAST) begin
                        state_next     = PRESSED;
                        level_next     = 1'b1;
                        press_next     = 1'b1;
                        cnt_next       = cnt_reg + 8'd1;
                        hold_next      = '0;
                        long_done_next = 1'b0;
                    end else begin
                        db_next = db_reg + 1'b1;
                    end
                end
                PRESSED: begin
                    hold_next = hold_reg + 1'b1;
                    if (hold_reg == LP_LAST) begin
                        long_next      = 1'b1;
                        long_done_next = 1'b1;
                        state_next     = HELD;
                    end
                    // A release seen on the long-press cycle still debounces, flag already set.
                    if (!p[gi]) begin
                        state_next = CHK_REL;
                        db_next    = '0;
                    end
                end
                HELD: begin
                    if (!p[gi]) begin
                        state_next = CHK_REL;
                        db_next    = '0;
                    end
                end
                CHK_REL: begin
                    if (p[gi]) begin
                        state_next = long_done_reg ? HELD : PRESSED;
                    end else if (db_reg == DB_LAST) begin
                        state_next   = IDLE;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        db_next = db_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        assign btn_level[gi]         = level_reg;
        assign btn_press[gi]         = press_reg;
        assign btn_release[gi]       = release_reg;
        assign btn_long[gi]          = long_reg;
        assign press_cnt[8*gi +: 8]  = cnt_reg;
    end

endmodule
